// File: rtl/qam_bit_unpacker_if.sv
// Streaming bus bundle for qam_bit_unpacker: one word-wide sink (asi_in0_*)
// and one symbol-wide source (aso_out0_*). Parameters must match the ones
// given to qam_bit_unpacker.
interface qam_bit_unpacker_if #(
    parameter int IN_WIDTH  = 8,
    parameter int QAM_STAGE = 4
);
    localparam int SYM_WIDTH = $clog2(QAM_STAGE);
    localparam int NSYM      = IN_WIDTH / SYM_WIDTH;
    localparam int EMPTY_W   = (NSYM > 1) ? $clog2(NSYM) : 1;

    logic [IN_WIDTH-1:0]  asi_in0_data;
    logic                 asi_in0_valid;
    logic                 asi_in0_ready;
    logic                 asi_in0_startofpacket;
    logic                 asi_in0_endofpacket;
    logic [EMPTY_W-1:0]   asi_in0_empty;

    logic [SYM_WIDTH-1:0] aso_out0_data;
    logic                 aso_out0_valid;
    logic                 aso_out0_ready;
    logic                 aso_out0_startofpacket;
    logic                 aso_out0_endofpacket;
    logic                 aso_out0_empty;

    // Unpacker side: sinks words, sources symbols.
    modport slave (
        input  asi_in0_data, asi_in0_valid, asi_in0_startofpacket,
        input  asi_in0_endofpacket, asi_in0_empty,
        output asi_in0_ready,
        output aso_out0_data, aso_out0_valid, aso_out0_startofpacket,
        output aso_out0_endofpacket, aso_out0_empty,
        input  aso_out0_ready
    );

    // Environment side: sources words, sinks symbols.
    modport master (
        output asi_in0_data, asi_in0_valid, asi_in0_startofpacket,
        output asi_in0_endofpacket, asi_in0_empty,
        input  asi_in0_ready,
        input  aso_out0_data, aso_out0_valid, aso_out0_startofpacket,
        input  aso_out0_endofpacket, aso_out0_empty,
        output aso_out0_ready
    );
endinterface

// File: rtl/qam_bit_unpacker.sv
// qam_bit_unpacker: splits each input word into NSYM symbols of SYM_WIDTH
// bits for the QAM modulation stage, one symbol per accepted output beat.
// Symbol order is MSB-first by default; define QAM_UNPACK_LSB_FIRST_EN for
// LSB-first order. Handshake and latency are the same in both builds.
module qam_bit_unpacker #(
    parameter int IN_WIDTH  = 8,
    parameter int QAM_STAGE = 4
) (
    input  logic                clock_clk,
    input  logic                reset_reset,
    qam_bit_unpacker_if.slave   bus
);
    localparam int SYM_WIDTH = $clog2(QAM_STAGE);
    localparam int NSYM      = IN_WIDTH / SYM_WIDTH;
    localparam int IDX_W     = (NSYM > 1) ? $clog2(NSYM) : 1;
    localparam int EMPTY_W   = (NSYM > 1) ? $clog2(NSYM) : 1;

    typedef enum logic {ST_EMPTY, ST_LOADED} state_t;

    state_t                state_q, state_d;
    logic [IN_WIDTH-1:0]   word_p0;
    logic [IDX_W-1:0]      idx_q;
    logic [IDX_W-1:0]      last_q;
    logic                  sop_q, eop_q;
    logic                  in_ready, in_fire, out_fire, is_last;

    // Index of the final symbol of a word; padding is clipped so that at
    // least one symbol is always emitted.
    function automatic logic [IDX_W-1:0] last_index(input logic eop,
                                                    input logic [EMPTY_W-1:0] empty);
        int n_pad;
        n_pad = eop ? int'(empty) : 0;
        if (n_pad > NSYM - 1) n_pad = NSYM - 1;
        return IDX_W'(NSYM - 1 - n_pad);
    endfunction

    // Symbol idx of the held word in the configured bit order.
    function automatic logic [SYM_WIDTH-1:0] pick_symbol(input logic [IN_WIDTH-1:0] word,
                                                         input logic [IDX_W-1:0] idx);
`ifdef QAM_UNPACK_LSB_FIRST_EN
        return word[int'(idx)*SYM_WIDTH +: SYM_WIDTH];
`else
        return word[(NSYM-1-int'(idx))*SYM_WIDTH +: SYM_WIDTH];
`endif
    endfunction

    // Ready is combinational from the downstream ready so the next word can
    // load in the same cycle the last symbol leaves (no bubble).
    assign is_last  = (idx_q == last_q);
    assign in_ready = reset_reset &&
                      ((state_q == ST_EMPTY) || (is_last && bus.aso_out0_ready));
    assign in_fire  = bus.asi_in0_valid && in_ready;
    assign out_fire = (state_q == ST_LOADED) && bus.aso_out0_ready;

    // State register.
    always_ff @(posedge clock_clk) begin
        if (!reset_reset) state_q <= ST_EMPTY;
        else              state_q <= state_d;
    end

    // Next-state: load on accept, drain to EMPTY after the last symbol.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY:  if (in_fire) state_d = ST_LOADED;
            ST_LOADED: if (out_fire && is_last) state_d = in_fire ? ST_LOADED : ST_EMPTY;
            default:   state_d = ST_EMPTY;
        endcase
    end

    // Outputs: symbol, framing flags and input ready.
    always_comb begin
        bus.aso_out0_valid         = 1'b0;
        bus.aso_out0_data          = '0;
        bus.aso_out0_startofpacket = 1'b0;
        bus.aso_out0_endofpacket   = 1'b0;
        bus.aso_out0_empty         = 1'b0;
        bus.asi_in0_ready          = in_ready;
        if (state_q == ST_LOADED) begin
            bus.aso_out0_valid         = 1'b1;
            bus.aso_out0_data          = pick_symbol(word_p0, idx_q);
            bus.aso_out0_startofpacket = sop_q && (idx_q == '0);
            bus.aso_out0_endofpacket   = eop_q && is_last;
        end
    end

    // Symbol index and per-word framing; reload takes priority over advance.
    always_ff @(posedge clock_clk) begin
        if (!reset_reset) begin
            idx_q  <= '0;
            last_q <= '0;
            sop_q  <= 1'b0;
            eop_q  <= 1'b0;
        end else if (in_fire) begin
            idx_q  <= '0;
            last_q <= last_index(bus.asi_in0_endofpacket, bus.asi_in0_empty);
            sop_q  <= bus.asi_in0_startofpacket;
            eop_q  <= bus.asi_in0_endofpacket;
        end else if (out_fire) begin
            idx_q  <= idx_q + IDX_W'(1);
        end
    end

    // Held word; only observed while LOADED, so it carries no reset.
    always_ff @(posedge clock_clk) begin
        if (in_fire) word_p0 <= bus.asi_in0_data;
    end
endmodule
